led_flow_sequencer: RTL and testbench

Sequencer for the board LED bank: divides the system clock into a step tick and steps a multi-LED pattern (rotate left, rotate right, ping-pong, all-blink) at a selectable rate. It sits between the user controls (enable, mode and speed switches) and the LED pins. It replaces free-running single-LED blink logic with one controller that owns the whole LED bank.

---
 rtl/led_flow_sequencer.sv | 168 ++++++++++++++++
 tb/tb_led_flow_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/led_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : led_flow_sequencer
//  Purpose  : Owns the board LED bank. Divides CLK into a base tick, and from
//             that a step, and advances a multi-LED pattern on each step.
//             The patterns are rotate left, rotate right, ping-pong and
//             all-blink.
//  Ports    : CLK        - system clock, rising edge
//             RSTn       - synchronous active-low reset
//             En         - run request (level)
//             Mode[1:0]  - 00 rot left, 01 rot right, 10 ping-pong, 11 blink
//             Speed[1:0] - step period = TICK_DIV * 2^Speed cycles
//             LED_out    - LED drive, 1 = lit (registered)
//             Step_pulse - high for the one cycle a new pattern is presented
//             Busy       - high while running
//  Revision : 1.0 - initial release
// ============================================================================
module led_flow_sequencer #(
    parameter int N_LED    = 4,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [1:0]       Speed,
    output logic [N_LED-1:0] LED_out,
    output logic             Step_pulse,
    output logic             Busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic          C_DIR_UP    = 1'b1;
    localparam logic          C_DIR_DOWN  = 1'b0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [N_LED-1:0] r_led;
    logic             r_step;
    logic             r_busy;
    logic [PW-1:0]    r_presc;
    logic [2:0]       r_cnt;
    logic             r_dir;
    logic [1:0]       r_mode;
    logic [1:0]       r_speed;

    logic             w_tick;
    logic [2:0]       w_cnt_last;
    logic             w_step;
    logic [N_LED-1:0] w_init;
    logic [N_LED-1:0] w_next;
    logic             w_next_dir;

    // Base tick on the last prescaler count; a step is the base tick that
    // closes a group of 2^Speed ticks.
    assign w_tick = (r_presc == C_PRESC_MAX);

    always_comb begin
        w_cnt_last = 3'd0;
        case (r_speed)
            2'd0:    w_cnt_last = 3'd0;
            2'd1:    w_cnt_last = 3'd1;
            2'd2:    w_cnt_last = 3'd3;
            default: w_cnt_last = 3'd7;
        endcase
    end

    assign w_step = w_tick && (r_cnt == w_cnt_last);

    // Pattern loaded when leaving IDLE, from the live Mode input.
    always_comb begin
        w_init = '0;
        case (Mode)
            2'b01:   w_init = {1'b1, {(N_LED-1){1'b0}}};
            2'b11:   w_init = '1;
            default: w_init = {{(N_LED-1){1'b0}}, 1'b1};
        endcase
    end

    // Next pattern on a step, from the latched mode.
    always_comb begin
        w_next     = r_led;
        w_next_dir = r_dir;
        case (r_mode)
            2'b00: w_next = {r_led[N_LED-2:0], r_led[N_LED-1]};
            2'b01: w_next = {r_led[0], r_led[N_LED-1:1]};
            2'b10: begin
                // Direction flips on the step that lands on an end bit, so the
                // next step already heads back (no dwell at the ends).
                if (r_dir == C_DIR_UP) begin
                    w_next     = r_led << 1;
                    w_next_dir = r_led[N_LED-2] ? C_DIR_DOWN : C_DIR_UP;
                end else begin
                    w_next     = r_led >> 1;
                    w_next_dir = r_led[1] ? C_DIR_UP : C_DIR_DOWN;
                end
            end
            default: w_next = ~r_led;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_presc <= '0;
            r_cnt   <= 3'd0;
            r_dir   <= C_DIR_UP;
            r_mode  <= 2'b00;
            r_speed <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_step <= 1'b0;
                    if (En) begin
                        r_mode  <= Mode;
                        r_speed <= Speed;
                        r_led   <= w_init;
                        r_presc <= '0;
                        r_cnt   <= 3'd0;
                        r_dir   <= C_DIR_UP;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_led  <= '0;
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!En) begin
                        // Stop wins over a coinciding step.
                        r_state <= S_IDLE;
                        r_led   <= '0;
                        r_busy  <= 1'b0;
                        r_step  <= 1'b0;
                        r_presc <= '0;
                        r_cnt   <= 3'd0;
                        r_dir   <= C_DIR_UP;
                    end else begin
                        r_step  <= w_step;
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        if (w_tick) begin
                            r_cnt <= w_step ? 3'd0 : r_cnt + 3'd1;
                        end
                        if (w_step) begin
                            r_led <= w_next;
                            r_dir <= w_next_dir;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign LED_out    = r_led;
    assign Step_pulse = r_step;
    assign Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_flow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_flow_sequencer
//  Purpose  : Self-checking bench for led_flow_sequencer (N_LED=4,
//             TICK_DIV=4). Directed scenarios followed by random control
//             activity, each cycle compared against a reference model that
//             derives the pattern from elapsed cycles since start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_flow_sequencer;

    localparam int N  = 4;
    localparam int TD = 4;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         En = 1'b0;
    logic [1:0]   Mode = 2'b00;
    logic [1:0]   Speed = 2'b00;
    logic [N-1:0] LED_out;
    logic         Step_pulse;
    logic         Busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit       m_run = 1'b0;
    int       m_elapsed = 0;
    bit [1:0] m_mode = 2'b00;
    bit [1:0] m_speed = 2'b00;

    led_flow_sequencer #(.N_LED(N), .TICK_DIV(TD)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .En         (En),
        .Mode       (Mode),
        .Speed      (Speed),
        .LED_out    (LED_out),
        .Step_pulse (Step_pulse),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Pattern after n steps, computed from the mode's rule directly.
    function automatic logic [N-1:0] pattern(input bit [1:0] md, input int n);
        int pos;
        logic [N-1:0] p;
        p = '0;
        case (md)
            2'b00: p[n % N] = 1'b1;
            2'b01: p[N - 1 - (n % N)] = 1'b1;
            2'b10: begin
                pos = n % (2 * (N - 1));
                if (pos >= N) pos = 2 * (N - 1) - pos;
                p[pos] = 1'b1;
            end
            default: p = (n % 2 == 0) ? '1 : '0;
        endcase
        return p;
    endfunction

    // Apply inputs for one edge, advance model, then check outputs.
    task automatic cyc(input bit rstn, input bit en, input bit [1:0] md, input bit [1:0] sp);
        int period;
        logic [N-1:0] exp_led;
        logic exp_pulse, exp_busy;
        RSTn = rstn; En = en; Mode = md; Speed = sp;
        @(posedge CLK);
        if (!rstn) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_elapsed = 0; m_mode = md; m_speed = sp;
            end
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            m_elapsed++;
        end
        #1;
        if (m_run) begin
            period    = TD * (1 << m_speed);
            exp_led   = pattern(m_mode, m_elapsed / period);
            exp_pulse = (m_elapsed > 0) && (m_elapsed % period == 0);
            exp_busy  = 1'b1;
        end else begin
            exp_led = '0; exp_pulse = 1'b0; exp_busy = 1'b0;
        end
        vectors++;
        assert (LED_out === exp_led) else begin
            miscompares++;
            $error("FAIL led t=%0t observed=%b expected=%b", $time, LED_out, exp_led);
        end
        vectors++;
        assert (Step_pulse === exp_pulse) else begin
            miscompares++;
            $error("FAIL step_pulse t=%0t observed=%b expected=%b", $time, Step_pulse, exp_pulse);
        end
        vectors++;
        assert (Busy === exp_busy) else begin
            miscompares++;
            $error("FAIL busy t=%0t observed=%b expected=%b", $time, Busy, exp_busy);
        end
    endtask

    initial begin
        // Reset held with En=1, then release into mode 00.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'b00, 2'd0);
        // Mode 00 speed 0: start plus wrap at +16.
        for (int i = 0; i < 18; i++) cyc(1'b1, 1'b1, 2'b00, 2'd0);
        cyc(1'b1, 1'b0, 2'b00, 2'd0);
        cyc(1'b1, 1'b0, 2'b00, 2'd0);
        // Mode 10 speed 1: ping-pong across both ends.
        for (int i = 0; i < 60; i++) cyc(1'b1, 1'b1, 2'b10, 2'd1);
        cyc(1'b1, 1'b0, 2'b10, 2'd1);
        // Mode 11 speed 3: blink at +32 and +64.
        for (int i = 0; i < 66; i++) cyc(1'b1, 1'b1, 2'b11, 2'd3);
        cyc(1'b1, 1'b0, 2'b11, 2'd3);
        // Mode 01 speed 0, mode switched mid-run (ignored), stop at +9, restart.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 2'b01, 2'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 2'b00, 2'd0);
        cyc(1'b1, 1'b0, 2'b00, 2'd0);
        // Restart in mode 00, reset at +6, restart with En held.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 2'b00, 2'd0);
        cyc(1'b0, 1'b1, 2'b00, 2'd0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 2'b00, 2'd0);
        // Random control activity.
        for (int i = 0; i < 3000; i++) begin
            bit r, e;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 79) != 0);
            cyc(r, e, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
